// File: rtl/fir_decimator.sv
// fir_decimator: drops FIR warm-up samples, keeps 1 of every DECIM, and
// buffers kept samples in a small FIFO with a valid/ready output.
// Ports:
//   clk, rst         clock, async active-high reset
//   filtered_signal  signed FIR output, one sample per clk
//   dec_data         FIFO head sample
//   dec_valid        FIFO non-empty
//   dec_ready        consumer accepts dec_data on this edge
//   fifo_level       FIFO occupancy
//   overflow         sticky, a kept sample was dropped
module fir_decimator #(
  parameter int DECIM      = 4,
  parameter int WARMUP     = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [15:0]                     filtered_signal,
  output logic [15:0]                     dec_data,
  output logic                            dec_valid,
  input  logic                            dec_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            overflow
);

  localparam int WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  logic [WW-1:0] warm_q, warm_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [15:0]   mem_d [FIFO_DEPTH];

  logic active;
  logic keep;
  logic full;
  logic pop;
  logic wr;

  assign active = (warm_q == WW'(WARMUP));
  assign keep   = active && (phase_q == '0);
  assign full   = (level_q == LW'(FIFO_DEPTH));
  assign pop    = dec_valid && dec_ready;
  // a pop on a full edge frees the slot the keep needs
  assign wr     = keep && (!full || pop);

  always_comb begin
    warm_d   = warm_q;
    phase_d  = phase_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    mem_d    = mem_q;

    if (!active) begin
      warm_d = warm_q + WW'(1);
    end else if (phase_q == PW'(DECIM - 1)) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + PW'(1);
    end

    if (wr) begin
      mem_d[wr_ptr_q] = filtered_signal;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    unique case ({wr, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (keep && !wr) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warm_q   <= '0;
      phase_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      mem_q    <= '{default: '0};
    end else begin
      warm_q   <= warm_d;
      phase_q  <= phase_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      mem_q    <= mem_d;
    end
  end

  assign dec_data   = mem_q[rd_ptr_q];
  assign dec_valid  = (level_q != '0);
  assign fifo_level = level_q;
  assign overflow   = ovf_q;

endmodule

// File: doc/fir_decimator.md
# fir_decimator

Downstream stage of the 9-tap FIR lowpass (~10 MHz cutoff, 100 MHz sampling). It consumes the filter's free-running 16-bit signed output every clock and discards the pipeline warm-up samples. It then keeps one sample in every DECIM, decimating 100 MS/s to 25 MS/s by default, and presents the kept samples through a small FIFO with a valid/ready handshake so a stalling consumer does not disturb the filter.

## Interface
- DECIM, 4: decimation ratio; legal range ≥1; 1 keeps every sample.
- WARMUP, 13: input samples discarded after reset release; legal range ≥0.
- FIFO_DEPTH, 4: output FIFO entries; power of two, ≥2.
- clk  in  1  100 MHz sampling clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- filtered_signal  in  16  signed FIR output, new sample every clk.
- dec_data  out  16  signed FIFO head sample.
- dec_valid  out  1  FIFO non-empty.
- dec_ready  in  1  consumer accepts dec_data this edge.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- overflow  out  1  sticky; a kept sample was dropped.

## Operation
- Edge numbering: edge 0 is the first rising clk edge with rst low.
- Warm-up counter:
  - Counts edges 0..WARMUP-1; no sample is kept during these edges.
  - Saturates at WARMUP and then enables the phase counter.
- Phase counter:
  - Starts at 0 on edge WARMUP; increments each edge; wraps DECIM-1→0.
  - "Keep" asserts on edges where phase==0, so kept edges are WARMUP, WARMUP+DECIM, and so on.
  - With DECIM=1 every post-warm-up edge is a keep.
- On a keep edge, the filtered_signal value present before that edge is written into the FIFO.
- FIFO:
  - Registered circular buffer with read/write pointers that wrap at FIFO_DEPTH.
  - dec_data is driven by the head entry; dec_valid=(level≠0).
  - Pop occurs on an edge where dec_valid && dec_ready.
- Boundary rules, evaluated per edge:
  - Keep, not full: write; level increments, unless a pop occurs on the same edge, in which case level is unchanged.
  - Keep, full, pop on the same edge: the pop frees a slot and the write is accepted; level stays FIFO_DEPTH; no overflow.
  - Keep, full, no pop: the sample is dropped; overflow sets to 1 and stays set until rst.
  - Empty with a keep on the same edge: there is no bypass path. The sample becomes visible after that edge, and dec_ready on that edge has no effect.
  - Pop when empty: impossible; dec_ready is ignored while dec_valid=0.
- Sample values pass unmodified: no scaling, rounding or sign change.
- Reset, asserted at any time including mid-stream:
  - Immediately clears the pointers, level, phase counter, warm-up counter, overflow, dec_valid and dec_data.
  - After release, warm-up restarts from 0.

## Timing
- Reset values: dec_valid=0, dec_data=16'h0000, fifo_level=0, overflow=0.
- Latency: a sample kept on edge k drives dec_data with dec_valid=1 after edge k, provided the FIFO was empty. There is one clock of latency, and no combinational path from filtered_signal to any output.
- dec_ready affects state only at rising edges. Outputs are registered or come directly from FIFO registers.
- While dec_valid=1 and dec_ready=0, dec_data and dec_valid hold stable.
- Steady-state throughput is one sample per DECIM cycles. A consumer holding dec_ready=1 never causes overflow.

## Test plan
Defaults unless stated. "Ramp" means filtered_signal equals the edge number on each edge (0, 1, 2, …).
1. Ramp with dec_ready=1:
   - dec_valid first rises after edge 13 with dec_data=13.
   - Subsequent samples are 17, 21, 25, …, one each 4 cycles; each is valid for exactly 1 cycle.
   - fifo_level never exceeds 1; overflow=0.
2. Ramp with dec_ready=0:
   - FIFO holds 13, 17, 21, 25; fifo_level=4.
   - Sample 29 is dropped and overflow=1 after edge 29.
   - Raising dec_ready then drains 13, 17, 21, 25, 33 in order; overflow stays 1.
3. FIFO full with dec_ready pulsed high only on keep edge 29:
   - Entry 13 is popped and 29 is written; fifo_level stays 4; overflow=0.
   - Draining yields 17, 21, 25, 29.
4. Assert rst asynchronously between edges 20 and 21:
   - dec_valid, fifo_level and overflow drop immediately, before the next edge.
   - After release, the first kept sample is at the new edge 13.
5. DECIM=1, WARMUP=0, ramp, dec_ready=1: dec_data equals the previous edge's input each cycle (0, 1, 2, …); dec_valid is continuously high from after edge 0.
6. Backpressure hold:
   - dec_ready toggles 1 0 0 1 on consecutive edges with samples pending.
   - dec_data stays stable through the 0 cycles; no sample is duplicated or lost (checked against the ramp model).
